// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
//   Bundles the two byte-stream requester ports, the uart_top transmit
//   handshake and the arbiter status outputs into one connection.
//   Port summary:
//     reqX_valid / reqX_data[7:0] / reqX_last : requester X byte stream
//     reqX_ready                              : requester X byte accepted
//     tx_busy                                 : busy output of uart_top
//     tx_data[7:0] / tx_stb                   : byte and strobe to uart_top
//     grant[1:0]                              : one-hot owner, 00 = none
//     timeout_pulse                           : grant revoked by timeout
//   Modports:
//     master : the arbiter itself (drives ready, tx_data, tx_stb, status)
//     slave  : the surroundings (requesters and uart_top)
interface uart_tx_arbiter_if;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_last;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_last;
    logic       req1_ready;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       tx_stb;
    logic [1:0] grant;
    logic       timeout_pulse;

    modport master (
        input  req0_valid, req0_data, req0_last,
        input  req1_valid, req1_data, req1_last,
        input  tx_busy,
        output req0_ready, req1_ready,
        output tx_data, tx_stb, grant, timeout_pulse
    );

    modport slave (
        output req0_valid, req0_data, req0_last,
        output req1_valid, req1_data, req1_last,
        output tx_busy,
        input  req0_ready, req1_ready,
        input  tx_data, tx_stb, grant, timeout_pulse
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one uart_top transmitter between two byte-stream requesters
//   (port 0: board/score printer, port 1: status/debug messages).
//   Arbitration is per packet: the owner keeps the grant until its last
//   byte has been transmitted or it goes HOLD_TIMEOUT cycles without
//   presenting a byte. Each byte is sent as a one-cycle tx_stb, then a wait
//   for tx_busy to rise (bounded by BUSY_LAT) and to fall again.
//   Ports:
//     clk   : system clock
//     rst_n : asynchronous active-low reset
//     bus   : uart_tx_arbiter_if.master (requesters, uart_top, status)
module uart_tx_arbiter #(
    parameter int HOLD_TIMEOUT = 1024,
    parameter int BUSY_LAT     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    uart_tx_arbiter_if.master      bus
);

    localparam int IDLE_W = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
    localparam int LAT_W  = (BUSY_LAT > 1) ? $clog2(BUSY_LAT) : 1;
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(HOLD_TIMEOUT - 1);
    localparam logic [LAT_W-1:0]  LAT_MAX  = LAT_W'(BUSY_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STB,
        S_WAIT_HI,
        S_WAIT_LO
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic              last_grant_q, last_grant_d;   // index of previous owner
    logic [7:0]        tx_data_q, tx_data_d;
    logic              last_flag_q, last_flag_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic              timeout_q, timeout_d;

    logic       win_idx;
    logic       accept;
    logic [7:0] owner_data;
    logic       owner_last;

    // On a tie the requester that did not own the UART last time wins.
    assign win_idx = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q
                                                        : bus.req1_valid;

    assign accept     = (state_q == S_LOAD) &&
                        ((grant_q[0] && bus.req0_valid) ||
                         (grant_q[1] && bus.req1_valid));
    assign owner_data = grant_q[1] ? bus.req1_data : bus.req0_data;
    assign owner_last = grant_q[1] ? bus.req1_last : bus.req0_last;

    // Outputs decode registered state only, so reset clears them at once.
    assign bus.req0_ready    = (state_q == S_LOAD) && grant_q[0];
    assign bus.req1_ready    = (state_q == S_LOAD) && grant_q[1];
    assign bus.tx_stb        = (state_q == S_STB);
    assign bus.tx_data       = tx_data_q;
    assign bus.grant         = grant_q;
    assign bus.timeout_pulse = timeout_q;

    always_comb begin
        // NOTE: every variable written here gets a default first; a path
        // that skips an assignment would otherwise infer a latch.
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        tx_data_d    = tx_data_q;
        last_flag_d  = last_flag_q;
        idle_cnt_d   = idle_cnt_q;
        lat_cnt_d    = lat_cnt_q;
        timeout_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // No new grant while uart_top is still busy from before.
                if (!bus.tx_busy && (bus.req0_valid || bus.req1_valid)) begin
                    grant_d      = win_idx ? 2'b10 : 2'b01;
                    last_grant_d = win_idx;
                    idle_cnt_d   = '0;
                    state_d      = S_LOAD;
                end
            end
            S_LOAD: begin
                // An accept on the threshold cycle wins over the timeout.
                if (accept) begin
                    tx_data_d   = owner_data;
                    last_flag_d = owner_last;
                    idle_cnt_d  = '0;
                    state_d     = S_STB;
                end else if (idle_cnt_q == IDLE_MAX) begin
                    timeout_d  = 1'b1;
                    grant_d    = 2'b00;
                    idle_cnt_d = '0;
                    state_d    = S_IDLE;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            S_STB: begin
                lat_cnt_d = '0;
                state_d   = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (bus.tx_busy) begin
                    state_d = S_WAIT_LO;
                end else if (lat_cnt_q == LAT_MAX) begin
                    // Busy never showed up: the byte is taken as sent.
                    state_d = last_flag_q ? S_IDLE : S_LOAD;
                    if (last_flag_q) grant_d = 2'b00;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end
            S_WAIT_LO: begin
                if (!bus.tx_busy) begin
                    state_d = last_flag_q ? S_IDLE : S_LOAD;
                    if (last_flag_q) grant_d = 2'b00;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            grant_q      <= 2'b00;
            last_grant_q <= 1'b1;     // requester 0 wins the first tie
            tx_data_q    <= 8'h00;
            last_flag_q  <= 1'b0;
            idle_cnt_q   <= '0;
            lat_cnt_q    <= '0;
            timeout_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            tx_data_q    <= tx_data_d;
            last_flag_q  <= last_flag_d;
            idle_cnt_q   <= idle_cnt_d;
            lat_cnt_q    <= lat_cnt_d;
            timeout_q    <= timeout_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Directed bench for uart_tx_arbiter: requester queues drive the two byte
//   streams, an optional busy model emulates uart_top, and a monitor logs
//   every strobe (data, grant, cycle) for comparison with hand-computed
//   expectations.
module tb_uart_tx_arbiter;

    localparam int HOLD = 16;
    localparam int LAT  = 4;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } byte_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if bus();

    uart_tx_arbiter #(
        .HOLD_TIMEOUT(HOLD),
        .BUSY_LAT    (LAT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic byte_t mk(input logic [7:0] d, input logic l);
        byte_t b;
        b.data = d;
        b.last = l;
        return b;
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Requester drivers: present the queue head; pop it one negedge after
    // a cycle in which valid and ready were both high.
    byte_t q0[$];
    byte_t q1[$];
    logic  acc0, acc1;

    always @(negedge clk) begin
        if (!rst_n) begin
            acc0 = 1'b0;
            acc1 = 1'b0;
            bus.req0_valid = 1'b0;
            bus.req0_data  = 8'h00;
            bus.req0_last  = 1'b0;
            bus.req1_valid = 1'b0;
            bus.req1_data  = 8'h00;
            bus.req1_last  = 1'b0;
        end else begin
            if (acc0) void'(q0.pop_front());
            if (acc1) void'(q1.pop_front());
            bus.req0_valid = (q0.size() > 0);
            if (q0.size() > 0) begin
                bus.req0_data = q0[0].data;
                bus.req0_last = q0[0].last;
            end
            bus.req1_valid = (q1.size() > 0);
            if (q1.size() > 0) begin
                bus.req1_data = q1[0].data;
                bus.req1_last = q1[0].last;
            end
            acc0 = bus.req0_valid && bus.req0_ready;
            acc1 = bus.req1_valid && bus.req1_ready;
        end
    end

    // uart_top model: when enabled, busy is high for 10 cycles after a strobe.
    bit busy_en  = 1'b0;
    int busy_cnt = 0;

    always @(negedge clk) begin
        if (!rst_n || !busy_en) begin
            busy_cnt    = 0;
            bus.tx_busy = 1'b0;
        end else begin
            bus.tx_busy = (busy_cnt > 0);
            if (busy_cnt > 0) busy_cnt--;
            if (bus.tx_stb) busy_cnt = 10;
        end
    end

    // Strobe monitor.
    logic [7:0] sent_data[$];
    logic [1:0] sent_grant[$];
    int         sent_cyc[$];
    int         ready0_cnt = 0;
    int         tmo_cnt    = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            sent_data.delete();
            sent_grant.delete();
            sent_cyc.delete();
            ready0_cnt = 0;
            tmo_cnt    = 0;
        end else begin
            if (bus.tx_stb) begin
                sent_data.push_back(bus.tx_data);
                sent_grant.push_back(bus.grant);
                sent_cyc.push_back(cyc);
            end
            if (bus.req0_ready) ready0_cnt++;
            if (bus.timeout_pulse) tmo_cnt++;
        end
    end

    task automatic reset_dut();
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (!(q0.size() == 0 && q1.size() == 0 && bus.grant == 2'b00 &&
                 !bus.tx_busy && !bus.tx_stb) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, n < budget, 1);
        @(negedge clk);
    endtask

    task automatic wait_strobes(input int cnt, input int budget, input string tag);
        int n = 0;
        while (sent_data.size() < cnt && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, n < budget, 1);
    endtask

    task automatic check_log(input string tag, input logic [7:0] exp_d[],
                             input logic [1:0] exp_g[]);
        check({tag, "_count"}, sent_data.size(), exp_d.size());
        for (int i = 0; i < exp_d.size(); i++) begin
            if (i < sent_data.size()) begin
                check($sformatf("%s_data%0d", tag, i), sent_data[i], exp_d[i]);
                check($sformatf("%s_grant%0d", tag, i), sent_grant[i], exp_g[i]);
            end
        end
    endtask

    initial begin
        int n;
        int c0;
        int c1;

        // ---- Reset then single packet "AB" with busy model ----
        busy_en = 1'b1;
        reset_dut();
        check("rst_grant", bus.grant, 2'b00);
        check("rst_stb", bus.tx_stb, 1'b0);
        check("rst_data", bus.tx_data, 8'h00);
        check("rst_ready0", bus.req0_ready, 1'b0);
        check("rst_ready1", bus.req1_ready, 1'b0);
        check("rst_tmo", bus.timeout_pulse, 1'b0);

        @(posedge clk);
        q0.push_back(mk(8'h41, 1'b0));
        q0.push_back(mk(8'h42, 1'b1));
        @(negedge clk);                     // valid presented this cycle
        check("t1_grant_n", bus.grant, 2'b00);
        @(negedge clk);
        check("t1_grant_n1", bus.grant, 2'b01);
        check("t1_ready0", bus.req0_ready, 1'b1);
        @(negedge clk);
        check("t1_stb", bus.tx_stb, 1'b1);
        check("t1_stb_data", bus.tx_data, 8'h41);
        check("t1_ready0_stb", bus.req0_ready, 1'b0);
        wait_done(200, "t1_done");
        check_log("t1", '{8'h41, 8'h42}, '{2'b01, 2'b01});
        check("t1_ready0_cycles", ready0_cnt, 2);
        check("t1_grant_end", bus.grant, 2'b00);
        check("t1_data_hold", bus.tx_data, 8'h42);

        // ---- Tie and alternation, busy never rises ----
        busy_en = 1'b0;
        reset_dut();
        @(posedge clk);
        q0.push_back(mk(8'h10, 1'b0));
        q0.push_back(mk(8'h11, 1'b0));
        q0.push_back(mk(8'h12, 1'b1));
        q1.push_back(mk(8'h20, 1'b0));
        q1.push_back(mk(8'h21, 1'b1));
        wait_done(300, "t2_done_a");
        @(posedge clk);
        q0.push_back(mk(8'h30, 1'b1));
        q1.push_back(mk(8'h40, 1'b1));
        wait_done(300, "t2_done_b");
        check_log("t2",
                  '{8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h30, 8'h40},
                  '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b10});
        if (sent_cyc.size() >= 4) begin
            check("t2_gap01", sent_cyc[1] - sent_cyc[0], 6);
            check("t2_gap12", sent_cyc[2] - sent_cyc[1], 6);
            check("t2_gap23", sent_cyc[3] - sent_cyc[2], 7);
        end

        // ---- Packet lock: req1 arrives mid req0 packet ----
        busy_en = 1'b1;
        reset_dut();
        @(posedge clk);
        q0.push_back(mk(8'h50, 1'b0));
        q0.push_back(mk(8'h51, 1'b0));
        q0.push_back(mk(8'h52, 1'b0));
        q0.push_back(mk(8'h53, 1'b1));
        wait_strobes(2, 200, "t3_two_strobes");
        q1.push_back(mk(8'h60, 1'b1));
        wait_done(400, "t3_done");
        check_log("t3", '{8'h50, 8'h51, 8'h52, 8'h53, 8'h60},
                  '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10});

        // ---- Hold timeout ----
        busy_en = 1'b1;
        reset_dut();
        @(posedge clk);
        q0.push_back(mk(8'h70, 1'b0));
        q1.push_back(mk(8'h71, 1'b1));
        wait_strobes(1, 100, "t4_first_strobe");
        n = 0;
        while (!bus.req0_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t4_reload", n < 100, 1);
        c0 = cyc;
        n = 0;
        while (!bus.timeout_pulse && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t4_tmo_seen", n < 100, 1);
        c1 = cyc;
        check("t4_tmo_delay", c1 - c0, HOLD);
        check("t4_tmo_grant", bus.grant, 2'b00);
        @(negedge clk);
        check("t4_tmo_once", bus.timeout_pulse, 1'b0);
        check("t4_regrant", bus.grant, 2'b10);
        wait_done(200, "t4_done");
        check_log("t4", '{8'h70, 8'h71}, '{2'b01, 2'b10});
        check("t4_tmo_count", tmo_cnt, 1);

        // ---- Asynchronous reset during S_STB ----
        busy_en = 1'b0;
        reset_dut();
        @(posedge clk);
        q0.push_back(mk(8'h80, 1'b0));
        q0.push_back(mk(8'h81, 1'b1));
        n = 0;
        while (!bus.tx_stb && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t5_stb_seen", n < 50, 1);
        #1 rst_n = 1'b0;
        #1;
        check("t5_async_stb", bus.tx_stb, 1'b0);
        check("t5_async_grant", bus.grant, 2'b00);
        check("t5_async_ready0", bus.req0_ready, 1'b0);
        check("t5_async_data", bus.tx_data, 8'h00);
        reset_dut();
        @(posedge clk);
        q0.push_back(mk(8'h82, 1'b1));
        q1.push_back(mk(8'h83, 1'b1));
        wait_done(200, "t5_done");
        check_log("t5", '{8'h82, 8'h83}, '{2'b01, 2'b10});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single uart_top transmitter between two byte-stream requesters: port 0 is the board/score printer, port 1 is the status/debug message source.
- Arbitration happens at packet granularity. Once a requester is granted, its bytes go out back-to-back until it marks the last byte or stalls past a timeout.
- Sequences the UART handshake: one-cycle strobe, wait for busy to rise, wait for busy to fall.
- Sits between the string generators and uart_top. Drives uart_top's data and strobe inputs and consumes its busy output.

Parameters:
- HOLD_TIMEOUT, 1024: idle cycles a granted owner may go without presenting a byte before its grant is revoked.
- BUSY_LAT, 4: maximum cycles to wait for tx_busy to rise after a strobe. If busy has not risen by then, the byte is treated as sent.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a byte.
- req0_data  in  8  requester 0 byte.
- req0_last  in  1  byte is the final byte of requester 0's packet.
- req0_ready  out  1  requester 0 byte accepted this cycle (when valid is also high).
- req1_valid  in  1  requester 1 has a byte.
- req1_data  in  8  requester 1 byte.
- req1_last  in  1  byte is the final byte of requester 1's packet.
- req1_ready  out  1  requester 1 byte accepted this cycle (when valid is also high).
- tx_busy  in  1  busy output from uart_top.
- tx_data  out  8  byte to uart_top.
- tx_stb  out  1  one-cycle transmit strobe to uart_top.
- grant  out  2  one-hot current owner; 00 means no owner.
- timeout_pulse  out  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset: already decided — one clock; reset is asynchronous and active-low.
  - Asserting rst_n low immediately clears: state to S_IDLE, tx_stb, tx_data (0x00), grant (00), timeout_pulse, both readies, all counters.
  - last_grant resets to 1, so requester 0 wins the first tie.
  - Reset mid-packet or mid-strobe drops the byte in flight; there is no replay.
- Ready decode is combinational from registered state: reqX_ready = (state==S_LOAD) && grant[X].
- A byte is accepted when reqX_valid && reqX_ready in the same cycle.
- FSM:
  - S_IDLE: grant=00. Arbitration runs only when tx_busy=0.
    - Only one valid: that requester wins.
    - Both valid: the winner is the requester other than last_grant.
    - On a win, grant and last_grant are registered and the FSM moves to S_LOAD. A valid seen in cycle N gives grant in cycle N+1.
  - S_LOAD: waits for the owner's valid.
    - On accept: capture data into tx_data, capture last into last_flag, clear the idle counter, go to S_STB.
    - Otherwise the idle counter increments. When it reaches HOLD_TIMEOUT-1 with no accept: pulse timeout_pulse for one cycle, set grant=00, go to S_IDLE. last_grant keeps the revoked owner, so the other requester has priority next.
    - The non-owner's valid is ignored (its ready is 0).
  - S_STB: tx_stb=1 for exactly one cycle; tx_data stable. Next state is S_WAIT_HI and the latency counter is cleared.
  - S_WAIT_HI:
    - tx_busy=1 goes to S_WAIT_LO.
    - Otherwise the counter increments. At BUSY_LAT-1 with tx_busy still 0, treat the byte as done and apply the completion rule.
  - S_WAIT_LO: tx_busy=0 applies the completion rule.
  - Completion rule: if last_flag=1, go to S_IDLE with grant=00; else go to S_LOAD with the same grant.
- Throughput: at minimum 1 byte per (UART frame + 3) cycles. An accept in cycle N gives tx_stb in cycle N+1.
- tx_data holds the last captured byte until the next capture; it is never cleared except by reset.
- A byte is never lost or duplicated: exactly one tx_stb per accepted byte.
- Simultaneous events:
  - An accept and the timeout threshold in the same cycle: the accept wins; no timeout pulse.
  - Completion with last=1 while the other requester is waiting: that requester is granted on the following S_IDLE cycle.
- Counter widths are $clog2 of the respective parameter, minimum 1 bit. No wrap is possible because each counter is cleared at its threshold.
- tx_busy already high in S_IDLE (e.g. after reset): no grant is issued until it falls.

Test Plan:
- Reset then single packet: req0 sends "AB" (0x41, 0x42 with last) while the busy model is high for 10 cycles after each strobe → exactly 2 tx_stb pulses with tx_data 0x41 then 0x42; grant=01 throughout, then 00; req0_ready high only in S_LOAD.
- Tie: both valid in the same cycle from reset → grant=01 first. After req0's 3-byte packet completes, grant=10. With both valid again, grant=01 (alternation).
- Packet lock: req1 raises valid mid-way through req0's 4-byte packet → no req1 byte is transmitted until req0's last byte completes; tx_data sequence is contiguous req0 bytes.
- Timeout: HOLD_TIMEOUT=16; req0 is granted, sends 1 non-last byte, then drops valid → timeout_pulse exactly 16 cycles after re-entering S_LOAD; grant goes to 00; waiting req1 is granted next cycle.
- Busy never rises: tx_busy tied 0, BUSY_LAT=4 → each byte completes 4 cycles after its strobe; a 3-byte packet yields 3 strobes.
- Async reset: assert rst_n low during S_STB → tx_stb, grant and readies are 0 immediately (before the next clock edge); after release, arbitration restarts with req0 priority.
